instr_fetch: RTL



---
 rtl/instr_fetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: loadable instruction memory, PC and IR.
// Field outputs are slices of IR for the downstream decoder.
module instr_fetch #(
  parameter int          ADDR_W    = 6,
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              run,
  input  logic              stall,
  output logic              instr_valid,
  output logic [31:0]       IR,
  output logic [5:0]        OP,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        func,
  output logic [31:0]       PC,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [MEM_DEPTH];
  logic [ADDR_W-1:0] pc_idx;
  logic [31:0]       fetch_word;
  logic              mem_we;
  logic              ir_load;
  logic              pc_inc;

  // Word index wraps modulo MEM_DEPTH while the PC keeps counting.
  assign pc_idx     = PC[ADDR_W+1:2];
  assign fetch_word = mem[pc_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (load_en)  mem_we    = 1'b1;
        else if (run) state_nxt = FETCH;
      end
      FETCH: begin
        if (fetch_word == HALT_WORD) begin
          state_nxt = HALT;
        end else begin
          ir_load   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          pc_inc    = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC <= RESET_PC;
      IR <= '0;
    end else begin
      if (ir_load) IR <= fetch_word;
      if (pc_inc)  PC <= PC + 32'd4;
    end
  end

  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);

  assign OP    = IR[31:26];
  assign rs    = IR[25:21];
  assign rt    = IR[20:16];
  assign rd    = IR[15:11];
  assign shamt = IR[10:6];
  assign func  = IR[5:0];

endmodule
